// File: rtl/pwm_duty_scheduler_pkg.sv
// pwm_ctrl_pkg: shared types and defaults for the PWM duty scheduler slice.
package pwm_ctrl_pkg;

  // Scheduler FSM encoding; the unused code 2'd3 is recovered to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // Default duty width; must match the PWM generator's compare width.
  localparam int DUTY_W_DEF = 4;

endpackage

// File: rtl/pwm_duty_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. The scan starts at ptr and wraps.
// It returns a one-hot grant and the encoded index of the winner.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Walk slots ptr, ptr+1, ... (mod N); the first requesting slot wins.
  always_comb begin
    logic found_v;
    logic hit_v;
    int   cand_v;
    gnt     = {N{1'b0}};
    idx     = {IW{1'b0}};
    found_v = 1'b0;
    hit_v   = 1'b0;
    cand_v  = 0;
    for (int off = 0; off < N; off++) begin
      cand_v      = (int'(ptr) + off) % N;
      hit_v       = req[cand_v] & ~found_v;
      gnt[cand_v] = gnt[cand_v] | hit_v;
      idx         = hit_v ? IW'(cand_v) : idx;
      found_v     = found_v | hit_v;
    end
  end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// pwm_duty_scheduler: arbitrates N_REQ duty requests round-robin.
// It ramps duty_out one LSB at a time toward the granted target. Steps only
// land on PWM period boundaries, so every PWM period runs at a single value.
module pwm_duty_scheduler
  import pwm_ctrl_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int DUTY_W       = DUTY_W_DEF,
  parameter  int PERIOD       = 16,
  parameter  int STEP_PERIODS = 2,
  localparam int ID_W         = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DUTY_W-1:0] req_duty,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DUTY_W-1:0]       duty_out,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    done
);

  localparam int PC_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SC_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  localparam logic [PC_W-1:0]   PC_LAST  = PC_W'(PERIOD - 1);
  localparam logic [PC_W-1:0]   PC_ONE   = PC_W'(1);
  localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(STEP_PERIODS - 1);
  localparam logic [SC_W-1:0]   SC_ONE   = SC_W'(1);
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_REQ - 1);
  localparam logic [ID_W-1:0]   ID_ONE   = ID_W'(1);
  localparam logic [DUTY_W-1:0] DUTY_ONE = DUTY_W'(1);

  // One LSB toward tgt. The result is never past tgt and never wraps.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    logic [DUTY_W-1:0] res;
    if (cur < tgt) begin
      res = cur + DUTY_ONE;
    end else if (cur > tgt) begin
      res = cur - DUTY_ONE;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  sched_state_t      state_r;
  sched_state_t      state_nx_s;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [PC_W-1:0]   period_cnt_r;
  logic [SC_W-1:0]   step_cnt_r;
  logic [DUTY_W-1:0] target_r;
  logic [DUTY_W-1:0] duty_r;
  logic [ID_W-1:0]   grant_id_r;
  logic              busy_r;
  logic              done_r;

  logic [N_REQ-1:0]  arb_gnt_s;
  logic [ID_W-1:0]   arb_idx_s;
  logic [DUTY_W-1:0] sel_duty_s;
  logic [ID_W-1:0]   ptr_nx_s;
  logic              tick_s;
  logic              accept_s;
  logic              ramp_step_s;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s)
  );

  assign tick_s     = (period_cnt_r == PC_LAST);
  assign sel_duty_s = req_duty[int'(arb_idx_s)*DUTY_W +: DUTY_W];
  assign ptr_nx_s   = (arb_idx_s == ID_LAST) ? {ID_W{1'b0}} : (arb_idx_s + ID_ONE);

  assign duty_out = duty_r;
  assign grant_id = grant_id_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // FSM state register. busy/done are registered from the next state so they track state_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == RAMP) || (state_nx_s == DONE);
      done_r  <= (state_nx_s == DONE);
    end
  end

  // Next-state logic: accept, ramp until duty matches target, then one DONE cycle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          state_nx_s = RAMP;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RAMP: begin
        if (duty_r == target_r) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RAMP;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output/strobe decode: ready only in IDLE, and stepping only on ticks during RAMP.
  always_comb begin
    req_ready   = {N_REQ{1'b0}};
    accept_s    = 1'b0;
    ramp_step_s = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready = rst ? {N_REQ{1'b0}} : arb_gnt_s;
        accept_s  = |req_valid;
      end
      RAMP: begin
        ramp_step_s = tick_s && (duty_r != target_r);
      end
      DONE: begin
        req_ready = {N_REQ{1'b0}};
      end
      default: begin
        req_ready = {N_REQ{1'b0}};
      end
    endcase
  end

  // Free-running period counter, aligned with the PWM generator's counter by a shared reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt_r <= {PC_W{1'b0}};
    end else if (tick_s) begin
      period_cnt_r <= {PC_W{1'b0}};
    end else begin
      period_cnt_r <= period_cnt_r + PC_ONE;
    end
  end

  // Request capture and ramp datapath. A step written on a tick edge takes effect with the next period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r   <= {ID_W{1'b0}};
      step_cnt_r <= {SC_W{1'b0}};
      target_r   <= {DUTY_W{1'b0}};
      duty_r     <= {DUTY_W{1'b0}};
      grant_id_r <= {ID_W{1'b0}};
    end else if (accept_s) begin
      target_r   <= sel_duty_s;
      grant_id_r <= arb_idx_s;
      rr_ptr_r   <= ptr_nx_s;
      step_cnt_r <= {SC_W{1'b0}};
    end else if (ramp_step_s) begin
      if (step_cnt_r == SC_LAST) begin
        duty_r     <= step_toward(duty_r, target_r);
        step_cnt_r <= {SC_W{1'b0}};
      end else begin
        step_cnt_r <= step_cnt_r + SC_ONE;
      end
    end else begin
      step_cnt_r <= step_cnt_r;
    end
  end

endmodule
